button_debounce: RTL and testbench
==================================

# button_debounce

Front-end conditioner for the raw push-button that drives the seven-segment countdown/display controller's `button` input. It synchronises the asynchronous pad signal, filters contact bounce with a configurable stability window, and emits a clean level plus single-cycle press, release and long-press pulses. `btn_press` connects directly to the display controller's start/restart input.

## Interface
- `DB_CYCLES`, default 2_000_000: number of consecutive stable samples required to accept a level change (20 ms at 100 MHz); must be ≥ 1.
- `LONG_CYCLES`, default 100_000_000: cycles in HELD before `btn_long` fires (1 s at 100 MHz); must be > `DB_CYCLES`.
- `clk` in 1: system clock, 100 MHz; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_in` in 1: raw button pad, active-high, asynchronous to `clk`, bouncy.
- `btn_level` out 1: debounced level, high while the button is accepted as pressed.
- `btn_press` out 1: one-cycle pulse on an accepted press.
- `btn_release` out 1: one-cycle pulse on an accepted release.
- `btn_long` out 1: one-cycle pulse when a press has been held `LONG_CYCLES`; constant 0 when the feature is compiled out.

## Operation
- Two-flop synchroniser: `btn_in` → `s1` → `s0`. The FSM sees only `s0`.
- Stability counter `cnt`: width `$clog2(DB_CYCLES)`, minimum 1. It clears on every state change.
- FSM states and transitions:
  - IDLE: `s0`=1 → PRESS_WAIT with `cnt`=0.
  - PRESS_WAIT:
    - `s0`=0 → IDLE, with no outputs.
    - `s0`=1 and `cnt`==`DB_CYCLES`-1 → HELD.
    - Otherwise `cnt`+1.
  - HELD: `s0`=0 → RELEASE_WAIT with `cnt`=0.
  - RELEASE_WAIT:
    - `s0`=1 → HELD. This is a bounce: no `btn_press`, and the long counter is not reset.
    - `s0`=0 and `cnt`==`DB_CYCLES`-1 → IDLE.
    - Otherwise `cnt`+1.
- Output behaviour by transition:
  - `btn_level` is 1 in HELD and RELEASE_WAIT, 0 otherwise.
  - `btn_press` is 1 only in the first cycle after PRESS_WAIT→HELD.
  - `btn_release` is 1 only in the first cycle after RELEASE_WAIT→IDLE.
- All outputs are registered; there are no combinational paths from `btn_in`.
- Reset values: state IDLE; `s1`, `s0`, `cnt` and the long counter all 0; every output 0.
- Reset mid-operation: everything returns to its reset value immediately, and no pulse is emitted.
- Button held through reset deassertion: a full debounce runs, then `btn_press` fires. There is no suppression.
- Counters saturate and never wrap. `cnt` cannot exceed `DB_CYCLES`-1 by construction.

## Timing
- Press latency: `btn_in` first sampled high at edge k (stable thereafter) → `btn_press` and `btn_level` high after edge k+2+`DB_CYCLES`.
- Release latency is symmetric: `btn_release` high and `btn_level` low after edge k+2+`DB_CYCLES` from the first low sample.
- Pulse width: each pulse is exactly 1 cycle. There are no back-to-back pulses of the same kind.
- Minimum spacing between `btn_press` and the following `btn_release` is `DB_CYCLES`+1 cycles.
- A glitch shorter than `DB_CYCLES` cycles (after synchronisation) produces no output change.

## Configuration
- Macro: `BUTTON_DEBOUNCE_LONG_PRESS_EN`.
- Defined:
  - A long counter (width `$clog2(LONG_CYCLES)`) counts while in HELD or RELEASE_WAIT.
  - It clears on IDLE.
  - When it reaches `LONG_CYCLES`-1, `btn_long` pulses once. It then saturates, giving no repeat until the button is released to IDLE.
  - A bounce through RELEASE_WAIT back to HELD does not restart the long counter.
- Undefined: no long counter is built, and `btn_long` is tied to 0. All other behaviour is identical.

## Structure
- Package `button_pkg`:
  - `btn_state_t` enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT).
  - `DB_CYCLES_DEFAULT` and `LONG_CYCLES_DEFAULT` constants.
- Sub-module `sync_2ff`: a generic 2-flop synchroniser with async active-low reset, reset value 0. It is instantiated once.
- The FSM, counters and output registers live in `button_debounce`.

## Test plan
All scenarios use `DB_CYCLES`=4 and `LONG_CYCLES`=20.
- Clean press: `btn_in` rises before edge 0 and is held → `btn_press`=1 only after edge 6; `btn_level`=1 from edge 6.
- Bounce: `btn_in` toggles 1,0,1,0 per cycle, then stays 1 → no output until 6 edges after the final rise; then exactly one `btn_press`.
- Short glitch: `btn_in` high for 3 cycles, then 0 → `btn_level`, `btn_press` and `btn_release` all stay 0.
- Release bounce: from HELD, `btn_in` low for 2 cycles, high, then low and held → single `btn_release` 6 edges after the final fall; no extra `btn_press`.
- Long press (macro defined): hold for 40 cycles → `btn_long` pulses exactly once, 20 edges after entering HELD. With the macro undefined, `btn_long` stays 0.
- Reset mid-PRESS_WAIT: assert `rst_n`=0 asynchronously between clock edges → all outputs 0 immediately. Release reset with `btn_in` still high → `btn_press` fires 6 edges after the first post-reset edge.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// button_pkg: shared types and defaults for the push-button debouncer.
package button_pkg;

  // Debounce FSM states.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // 20 ms and 1 s at a 100 MHz system clock.
  localparam int DB_CYCLES_DEFAULT   = 2_000_000;
  localparam int LONG_CYCLES_DEFAULT = 100_000_000;

  // Width of a counter that must hold values 0 .. n-1, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// sync_2ff: generic two-flop synchroniser for asynchronous inputs.
// Both stages reset to 0 asynchronously.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  // Two back-to-back flops give metastability time to settle before q is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// button_debounce: synchronises and debounces the raw push-button pad and
// produces a clean level plus single-cycle press / release / long-press pulses.
// Optional long-press detection is built only when BUTTON_DEBOUNCE_LONG_PRESS_EN
// is defined; otherwise btn_long is tied low.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// IDLE         | button accepted as released
// PRESS_WAIT   | synchronised input high, counting stable samples
// HELD         | button accepted as pressed
// RELEASE_WAIT | synchronised input low, counting stable samples (level still 1)
module button_debounce
  import button_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
  parameter int LONG_CYCLES = LONG_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int            CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  // Empty marker scope: an illegal parameter set shows up in the hierarchy.
  if (DB_CYCLES < 1 || LONG_CYCLES <= DB_CYCLES) begin : g_bad_config
  end

  logic          s0;
  btn_state_t    state;
  btn_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          level_nxt;
  logic          press_nxt;
  logic          release_nxt;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (s0)
  );

  // State and stability-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; the stability counter restarts on every state change
  // and only advances while waiting, so it never passes CNT_LAST.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (s0) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s0) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HELD: begin
        if (!s0) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s0) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the transition being taken, so the registered outputs
  // line up with the state they describe.
  always_comb begin
    level_nxt   = (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
    press_nxt   = (state == PRESS_WAIT)   && (state_nxt == HELD);
    release_nxt = (state == RELEASE_WAIT) && (state_nxt == IDLE);
  end

  // Registered outputs: no combinational path from the pad.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_level   <= level_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
    end
  end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int            LW        = cnt_width(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] long_cnt;
  logic          long_done;
  logic          pressed;

  // RELEASE_WAIT counts as pressed so a release bounce does not restart the timer.
  assign pressed = (state == HELD) || (state == RELEASE_WAIT);

  // Long-press timer: saturates at LONG_LAST, fires once per press, clears once released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_cnt  <= '0;
      long_done <= 1'b0;
      btn_long  <= 1'b0;
    end else begin
      btn_long <= 1'b0;
      if (!pressed) begin
        long_cnt  <= '0;
        long_done <= 1'b0;
      end else if (long_cnt == LONG_LAST) begin
        if (!long_done) begin
          btn_long  <= 1'b1;
          long_done <= 1'b1;
        end
      end else begin
        long_cnt <= long_cnt + LW'(1);
      end
    end
  end
`else
  assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce with DB_CYCLES=4, LONG_CYCLES=20.
// A reference model pushes the expected outputs after every clock edge; a
// monitor on the falling edge pops and compares them against the DUT.
module tb_button_debounce;

  localparam int DB   = 4;
  localparam int LONG = 20;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic btn_in = 1'b0;
  logic btn_level, btn_press, btn_release, btn_long;

  button_debounce #(.DB_CYCLES(DB), .LONG_CYCLES(LONG)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_press = 0, n_release = 0, n_long = 0;

  // expected {level, press, release, long} after each edge
  logic [3:0] exp_q[$];

  // Reference model: the filter sees the pad two edges late; the accepted
  // level flips once DB+1 consecutive delayed samples all disagree with it.
  // A long press is the LONG-th edge spent with the level accepted high.
  bit raw[$];
  bit acc;
  int held;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw.delete();
      for (int i = 0; i < DB + 3; i++) raw.push_back(1'b0);
      acc  = 1'b0;
      held = 0;
    end else begin
      bit flip;
      bit lp;
      bit old;
      raw.push_back(btn_in);
      void'(raw.pop_front());
      // raw[DB] is the sample taken two edges ago; raw[0..DB] is the window
      flip = 1'b1;
      for (int i = 0; i <= DB; i++) if (raw[i] == acc) flip = 1'b0;
      old = acc;
      if (old) held++;
      lp = LONG_EN && old && (held == LONG);
      if (flip) begin
        acc = ~acc;
        if (acc) held = 0;
      end
      exp_q.push_back({acc, flip && !old, flip && old, lp});
    end
  end

  // Monitor: compare DUT outputs against the scoreboard away from the active edge.
  always @(negedge clk) begin
    logic [3:0] got;
    logic [3:0] want;
    got = {btn_level, btn_press, btn_release, btn_long};
    if (btn_press)   n_press++;
    if (btn_release) n_release++;
    if (btn_long)    n_long++;
    if (!rst_n) begin
      exp_q.delete();
      total++;
      if (got != 4'b0000) begin
        bad++;
        $display("FAIL reset_outputs t=%0t got=%b want=0000", $time, got);
      end
    end else if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_underflow t=%0t got=%b want=<model entry>", $time, got);
    end else begin
      want = exp_q.pop_front();
      total++;
      if (got != want) begin
        bad++;
        $display("FAIL cycle_outputs t=%0t got(lvl,prs,rel,lng)=%b want=%b", $time, got, want);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Drive the pad to v for n cycles; starts and ends just after a falling edge.
  task automatic hold(input bit v, input int n);
    btn_in = v;
    repeat (n) @(negedge clk);
    #1;
  endtask

  int p0, r0, l0;

  task automatic snap();
    p0 = n_press;
    r0 = n_release;
    l0 = n_long;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("reset_level", int'(btn_level), 0);
    rst_n = 1'b1;
    hold(0, 5);

    // clean press and release
    snap();
    hold(1, 12);
    check("clean_press_count", n_press - p0, 1);
    check("clean_press_level", int'(btn_level), 1);
    snap();
    hold(0, 12);
    check("clean_release_count", n_release - r0, 1);
    check("clean_release_level", int'(btn_level), 0);

    // press bounce
    snap();
    hold(1, 1); hold(0, 1); hold(1, 1); hold(0, 1);
    hold(1, 12);
    check("bounce_press_count", n_press - p0, 1);
    hold(0, 12);

    // short glitch
    snap();
    hold(1, 3);
    hold(0, 10);
    check("glitch_press_count", n_press - p0, 0);
    check("glitch_release_count", n_release - r0, 0);
    check("glitch_level", int'(btn_level), 0);

    // release bounce
    hold(1, 12);
    snap();
    hold(0, 2); hold(1, 1);
    hold(0, 12);
    check("relbounce_release_count", n_release - r0, 1);
    check("relbounce_press_count", n_press - p0, 0);

    // long press
    snap();
    hold(1, 40);
    check("long_count", n_long - l0, LONG_EN ? 1 : 0);
    hold(0, 12);

    // reset while HELD: level must drop without waiting for a clock edge
    hold(1, 12);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("reset_async_level", int'(btn_level), 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    snap();
    hold(1, 12);
    check("post_reset_press_count", n_press - p0, 1);
    hold(0, 12);

    // reset mid PRESS_WAIT with the button still held afterwards
    hold(1, 3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("reset_pw_press", int'(btn_press), 0);
    check("reset_pw_level", int'(btn_level), 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    snap();
    hold(1, 12);
    check("reset_pw_press_count", n_press - p0, 1);
    hold(0, 12);

    // randomized segments, occasionally with an asynchronous reset pulse
    for (int s = 0; s < 400; s++) begin
      int len;
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 30) : $urandom_range(1, 7);
      hold(1'($urandom_range(0, 1)), len);
      if ($urandom_range(0, 59) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk); #3;
        rst_n = 1'b1;
      end
    end
    hold(0, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
